// File: rtl/fir_pkg.sv
// Shared widths, limits and default parameters for the decimating FIR back end.
// Also provides the 18-bit to 8-bit saturating clip used by the scaler.
package fir_pkg;
  localparam int FIR_SUM_W = 17;
  localparam int SUM_W     = FIR_SUM_W + 1;
  localparam int OUT_W     = 8;
  localparam int SAT_MAX   = 255;
  localparam int DECIM_DEF = 4;
  localparam int SHIFT_DEF = 9;
  localparam int DEPTH_DEF = 4;
  localparam int PHASE_W   = 4;

  function automatic logic [OUT_W-1:0] clip(input logic [SUM_W-1:0] v);
    return (v > SUM_W'(SAT_MAX)) ? OUT_W'(SAT_MAX) : v[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head: a push is visible one cycle later, never same-cycle.
// Pushes into a full FIFO are refused unless a pop happens on the same edge.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = OUT_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_head_nxt;

  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CW'(DEPTH));
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign w_rd_nxt = r_rd + AW'(w_pop);
  assign o_dat    = r_head;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - CW'(1);
  end

  // The head register must pick up the incoming word when it becomes the sole entry.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push && (r_wr == w_rd_nxt))
      w_head_nxt = i_dat;
    if (w_cnt_nxt == '0)
      w_head_nxt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      r_rd   <= w_rd_nxt;
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr] <= i_dat;
  end
endmodule

// File: rtl/fir_decimator.sv
// Keeps every DECIM-th valid FIR sum, rounds/scales/saturates it to 8 bits, queues it in a FIFO.
// Two cycles from kept sample to OUT_VALID; a full FIFO without a pop drops the sample and sets OVERFLOW.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  input  logic [FIR_SUM_W-1:0] FIR_SUM,
  output logic [OUT_W-1:0]     OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OVERFLOW,
  output logic [7:0]           SAT_CNT
);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(DECIM - 1);
  localparam logic [SUM_W-1:0]   RND     = SUM_W'(1) << (SHIFT - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_s1_vld;
  logic [OUT_W-1:0]   r_s1_dat;
  logic               r_ovf;
  logic [7:0]         r_sat_cnt;

  logic               w_keep;
  logic               w_sat;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic [SUM_W-1:0]   w_rounded;
  logic [SUM_W-1:0]   w_scaled;

  assign w_keep    = IN_VALID && (r_phase == '0);
  // 18-bit sum cannot wrap: 2^17-1 plus at most 2^8 still fits.
  assign w_rounded = {1'b0, FIR_SUM} + RND;
  assign w_scaled  = w_rounded >> SHIFT;
  assign w_sat     = w_scaled > SUM_W'(SAT_MAX);
  assign w_pop     = OUT_VALID && OUT_READY;
  assign OUT_VALID = !w_empty;
  assign OVERFLOW  = r_ovf;
  assign SAT_CNT   = r_sat_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase   <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_dat  <= '0;
      r_ovf     <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (IN_VALID)
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PHASE_W'(1);
      r_s1_vld <= w_keep;
      if (w_keep)
        r_s1_dat <= clip(w_scaled);
      if (w_keep && w_sat && (r_sat_cnt != 8'(SAT_MAX)))
        r_sat_cnt <= r_sat_cnt + 8'd1;
      if (r_s1_vld && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (r_s1_vld),
    .i_dat   (r_s1_dat),
    .i_pop   (w_pop),
    .o_dat   (OUT_DATA),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 4, decimation factor, legal range 1..16.
REQ-002 SHALL have parameter SHIFT, default 9, right-shift applied to the filter sum, legal range 1..9.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO depth, power of two, 2..16.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port IN_VALID, input, 1 bit: FIR_SUM holds a new filter output this cycle.
REQ-007 SHALL have port FIR_SUM, input, 17 bits, unsigned: output of the upstream FIR low-pass stage.
REQ-008 SHALL have port OUT_DATA, output, 8 bits, unsigned: decimated, scaled sample at the FIFO head.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA is valid.
REQ-010 SHALL have port OUT_READY, input, 1 bit: the consumer accepts OUT_DATA this cycle.
REQ-011 SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when a kept sample is dropped.
REQ-012 SHALL have port SAT_CNT, output, 8 bits: count of saturated samples, holding at 255.

Function
REQ-013 SHALL keep a phase counter 0..DECIM-1 that advances only on cycles where IN_VALID=1, wrapping from DECIM-1 to 0.
REQ-014 SHALL keep a sample only when IN_VALID=1 and phase=0; samples at other phases are discarded; DECIM=1 keeps every valid sample.
REQ-015 SHALL compute the scaled value in 18 bits as (FIR_SUM + 2^(SHIFT-1)) >> SHIFT (round half up), with no wrap.
REQ-016 SHALL saturate a scaled value greater than 255 to 255 and increment SAT_CNT, which holds at 255 once reached.
REQ-017 SHALL register the scaled sample and a stage-valid bit in stage 1, one cycle after acceptance.
REQ-018 SHALL write that stage-1 sample into the FIFO on the following edge.
REQ-019 SHALL give 2-cycle latency with an empty FIFO: a sample kept in cycle t appears with OUT_VALID=1 in cycle t+2.
REQ-020 SHALL drive OUT_VALID=1 exactly when FIFO occupancy is greater than 0; OUT_DATA SHALL be the oldest entry.
REQ-021 SHALL pop one entry on each cycle where OUT_VALID=1 and OUT_READY=1; OUT_READY SHALL be ignored when the FIFO is empty.
REQ-022 SHALL, when the FIFO is full and no pop occurs in the write cycle, drop the stage-1 sample, set OVERFLOW=1 and leave the FIFO contents unchanged.
REQ-023 SHALL, when the FIFO is full and a pop occurs in the same cycle as a write, accept the write with occupancy unchanged.
REQ-024 SHALL, when the FIFO is empty, not allow a write in cycle t to be popped in cycle t; the bypass path is prohibited.
REQ-025 SHALL hold OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 SHALL clear OVERFLOW only by reset.

Reset
REQ-027 SHALL, while RST=1 at a clock edge, clear the phase to 0, the stage-1 valid bit to 0 and FIFO occupancy, read pointer and write pointer to 0.
REQ-028 SHALL drive OUT_VALID=0, OUT_DATA=0, OVERFLOW=0 and SAT_CNT=0 after reset.
REQ-029 SHALL, if reset is asserted mid-stream, discard in-flight stage-1 and FIFO data; the first valid sample after release is kept (phase 0).
REQ-030 SHALL ignore IN_VALID and OUT_READY during reset.

Structure
REQ-031 SHALL place in the shared package fir_pkg: FIR_SUM_W=17, OUT_W=8, SAT_MAX=255, and the default DECIM, SHIFT and DEPTH values.
REQ-032 SHALL implement the FIFO as one sub-module, sync_fifo: parameterised width and depth, registered head output, full/empty flags and simultaneous push/pop.
REQ-033 SHALL keep the phase counter, scaler and stage 1 in the top module, fir_decimator.

Verification
REQ-034 SHALL cover DECIM=4 with IN_VALID=1 continuous, FIR_SUM=512,1024,...,(k+1)*512 and OUT_READY=1 -> OUT_DATA=1,5,9,13 and OUT_VALID first high 2 cycles after the first sample.
REQ-035 SHALL cover DECIM=1: FIR_SUM=255 -> 0; 256 -> 1; 131071 -> 256 saturated to 255 with SAT_CNT=1; 300 consecutive saturating inputs -> SAT_CNT=255.
REQ-036 SHALL cover DECIM=1, DEPTH=4, OUT_READY=0, with 5 kept samples 512..2560 -> FIFO holds 1,2,3,4; the 5th is dropped; OVERFLOW=1 and stays 1 after OUT_READY=1 drains 1,2,3,4.
REQ-037 SHALL cover a full FIFO with OUT_READY=1 and a write in the same cycle -> occupancy stays 4, output order is preserved, and OVERFLOW stays 0.
REQ-038 SHALL cover gapped IN_VALID (1,0,0,1,1,0,1,1) with DECIM=2 -> exactly the 1st, 3rd and 5th valid samples are kept.
REQ-039 SHALL cover RST pulsed for one cycle with 3 entries queued and the phase at 2 -> OUT_VALID=0 next cycle, SAT_CNT=0, OVERFLOW=0, and the next valid sample is kept.
